// File: rtl/token_pkg.sv
`default_nettype none
// ============================================================================
// token_pkg : token field widths and packed head-word layout
// Rev 1.0
// ============================================================================
package token_pkg;

    localparam int DATA_W  = 144;
    localparam int POS_W   = 16;
    localparam int ADDR_W  = 17;
    localparam int GARB_W  = 2;
    localparam int TOKEN_W = DATA_W + POS_W + ADDR_W + GARB_W + 1;

    // MSB-first order matches the queue head word {data, position, address, garbage, lit}
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [POS_W-1:0]  position;
        logic [ADDR_W-1:0] address;
        logic [GARB_W-1:0] garbage;
        logic              lit_flag;
    } token_t;

endpackage : token_pkg
`default_nettype wire

// File: rtl/token_queue_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// rr_pick : combinational round-robin picker, first request at or above ptr
// Rev 1.0
// ============================================================================
module rr_pick #(
    parameter int NUM_Q = 4,
    parameter int IDX_W = $clog2(NUM_Q)
) (
    input  logic [NUM_Q-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NUM_Q-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any
);

    logic [2*NUM_Q-1:0] w_mask;
    logic [2*NUM_Q-1:0] w_dbl;
    logic               w_found;

    // Upper copy is unmasked so the scan wraps past NUM_Q-1 back to 0
    assign w_mask = {(2*NUM_Q){1'b1}} << ptr;
    assign w_dbl  = {req, req} & w_mask;
    assign any    = |req;

    always_comb begin
        w_found = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < 2*NUM_Q; i++) begin
            if (!w_found && w_dbl[i]) begin
                w_found = 1'b1;
                gnt_idx = IDX_W'(i % NUM_Q);
            end
        end
        gnt = NUM_Q'(w_found) << gnt_idx;
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/token_queue_arbiter.sv
`default_nettype none
// ============================================================================
// token_queue_arbiter : round-robin merge of NUM_Q show-ahead token queues
// into one registered token stream. Rev 1.0
// ============================================================================
module token_queue_arbiter
    import token_pkg::*;
#(
    parameter int NUM_Q = 4,
    parameter int IDX_W = $clog2(NUM_Q)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_Q-1:0]         q_valid,
    input  logic [NUM_Q-1:0]         q_enable,
    input  logic [NUM_Q*TOKEN_W-1:0] q_data,
    output logic [NUM_Q-1:0]         q_rdreq,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [POS_W-1:0]         out_position,
    output logic [ADDR_W-1:0]        out_address,
    output logic [GARB_W-1:0]        out_garbage,
    output logic                     out_lit_flag,
    output logic [IDX_W-1:0]         out_src,
    output logic [31:0]              tok_count
);

    token_t           w_slot [NUM_Q];
    token_t           w_sel;
    logic [NUM_Q-1:0] w_elig;
    logic [NUM_Q-1:0] w_gnt;
    logic [IDX_W-1:0] w_gnt_idx;
    logic [IDX_W-1:0] w_ptr_nxt;
    logic             w_any;
    logic             w_space;
    logic             w_fire;

    token_t           r_tok;
    logic             r_out_valid;
    logic [IDX_W-1:0] r_src;
    logic [IDX_W-1:0] r_ptr;
    logic [NUM_Q-1:0] r_cool;
    logic [31:0]      r_tok_count;

    generate
        for (genvar g = 0; g < NUM_Q; g++) begin : g_slot
            assign w_slot[g] = q_data[TOKEN_W*g +: TOKEN_W];
        end
    endgenerate

    // A just-popped queue still shows its old head for one cycle, hence cooldown
    assign w_elig = q_valid & q_enable & ~r_cool;

    rr_pick #(
        .NUM_Q (NUM_Q),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req     (w_elig),
        .ptr     (r_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx),
        .any     (w_any)
    );

    assign w_space   = ~r_out_valid | out_ready;
    assign w_fire    = w_space & w_any & ~rst;
    assign q_rdreq   = w_fire ? w_gnt : '0;
    assign w_sel     = w_slot[w_gnt_idx];
    assign w_ptr_nxt = (w_gnt_idx == IDX_W'(NUM_Q-1)) ? '0 : w_gnt_idx + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_tok       <= '0;
            r_src       <= '0;
            r_ptr       <= '0;
            r_cool      <= '0;
        end else if (w_fire) begin
            r_out_valid <= 1'b1;
            r_tok       <= w_sel;
            r_src       <= w_gnt_idx;
            r_ptr       <= w_ptr_nxt;
            r_cool      <= w_gnt;
        end else begin
            if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            r_cool <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tok_count <= '0;
        end else if (r_out_valid && out_ready) begin
            r_tok_count <= r_tok_count + 32'd1;
        end
    end

    assign out_valid    = r_out_valid;
    assign out_data     = r_tok.data;
    assign out_position = r_tok.position;
    assign out_address  = r_tok.address;
    assign out_garbage  = r_tok.garbage;
    assign out_lit_flag = r_tok.lit_flag;
    assign out_src      = r_src;
    assign tok_count    = r_tok_count;

endmodule : token_queue_arbiter
`default_nettype wire

// File: tb/tb_token_queue_arbiter.sv
`default_nettype none
// ============================================================================
// tb_token_queue_arbiter : directed self-checking bench for token_queue_arbiter
// Rev 1.0
// ============================================================================
module tb_token_queue_arbiter;
    import token_pkg::*;

    localparam int NQ = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NQ-1:0]         q_valid = '0;
    logic [NQ-1:0]         q_enable = '1;
    logic [NQ*TOKEN_W-1:0] q_data = '0;
    logic [NQ-1:0]         q_rdreq;
    logic                  out_valid;
    logic                  out_ready = 1'b1;
    logic [DATA_W-1:0]     out_data;
    logic [POS_W-1:0]      out_position;
    logic [ADDR_W-1:0]     out_address;
    logic [GARB_W-1:0]     out_garbage;
    logic                  out_lit_flag;
    logic [1:0]            out_src;
    logic [31:0]           tok_count;

    int n_cmp = 0;
    int n_err = 0;
    int rem [NQ];
    int seq [NQ];

    token_queue_arbiter #(.NUM_Q(NQ)) dut (
        .clk          (clk),
        .rst          (rst),
        .q_valid      (q_valid),
        .q_enable     (q_enable),
        .q_data       (q_data),
        .q_rdreq      (q_rdreq),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_position (out_position),
        .out_address  (out_address),
        .out_garbage  (out_garbage),
        .out_lit_flag (out_lit_flag),
        .out_src      (out_src),
        .tok_count    (tok_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic token_t mk(input int lane, input int s);
        token_t t;
        t.data     = DATA_W'(lane * 1000 + s);
        t.position = POS_W'(s);
        t.address  = ADDR_W'(lane + 5);
        t.garbage  = GARB_W'(s);
        t.lit_flag = s[0];
        return t;
    endfunction

    // Lane model: rem = tokens left (-1 = endless), seq = index of current head
    task automatic refresh();
        for (int i = 0; i < NQ; i++) begin
            q_valid[i] = (rem[i] != 0);
            q_data[i*TOKEN_W +: TOKEN_W] = mk(i, seq[i]);
        end
    endtask

    task automatic set_rem(input int r0, input int r1, input int r2, input int r3);
        rem[0] = r0; rem[1] = r1; rem[2] = r2; rem[3] = r3;
        refresh();
        #1;
    endtask

    task automatic tick();
        logic [NQ-1:0] pop;
        pop = q_rdreq;
        @(posedge clk);
        #1;
        for (int i = 0; i < NQ; i++) begin
            if (pop[i]) begin
                seq[i]++;
                if (rem[i] > 0) rem[i]--;
            end
        end
        refresh();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        out_ready = 1'b1;
        q_enable = '1;
        for (int i = 0; i < NQ; i++) begin
            rem[i] = 0;
            seq[i] = 0;
        end
        refresh();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        logic [3:0] mask_exp [4];
        logic [1:0] mask_src [4];
        mask_exp[0] = 4'b0001; mask_exp[1] = 4'b0010; mask_exp[2] = 4'b1000; mask_exp[3] = 4'b0001;
        mask_src[0] = 2'd0;    mask_src[1] = 2'd1;    mask_src[2] = 2'd3;    mask_src[3] = 2'd0;

        // Reset state
        do_reset();
        check_val("rst_valid", 64'(out_valid), 64'd0);
        check_val("rst_count", 64'(tok_count), 64'd0);
        check_val("rst_src", 64'(out_src), 64'd0);
        check_val("rst_pos", 64'(out_position), 64'd0);
        check_val("rst_rdreq", 64'(q_rdreq), 64'd0);

        // Single queue, three tokens
        set_rem(3, 0, 0, 0);
        check_val("sq_rdreq_c0", 64'(q_rdreq), 64'b0001);
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k % 2 == 1) begin
                check_val("sq_valid", 64'(out_valid), 64'd1);
                check_val("sq_src", 64'(out_src), 64'd0);
                check_val("sq_pos", 64'(out_position), 64'((k - 1) / 2));
                check_val("sq_data", out_data[63:0], 64'((k - 1) / 2));
                check_val("sq_rdreq_cool", 64'(q_rdreq), 64'd0);
            end else begin
                check_val("sq_idle", 64'(out_valid), 64'd0);
                check_val("sq_rdreq", 64'(q_rdreq), (k < 6) ? 64'b0001 : 64'd0);
            end
        end
        check_val("sq_count", 64'(tok_count), 64'd3);

        // Two queues alternating at full rate
        do_reset();
        set_rem(-1, -1, 0, 0);
        check_val("alt_rdreq_c0", 64'(q_rdreq), 64'b0001);
        for (int k = 1; k <= 6; k++) begin
            tick();
            check_val("alt_valid", 64'(out_valid), 64'd1);
            check_val("alt_src", 64'(out_src), 64'((k - 1) % 2));
            check_val("alt_pos", 64'(out_position), 64'((k - 1) / 2));
            check_val("alt_addr", 64'(out_address), 64'(((k - 1) % 2) + 5));
            check_val("alt_rdreq", 64'(q_rdreq), (k % 2 == 1) ? 64'b0010 : 64'b0001);
        end
        check_val("alt_count", 64'(tok_count), 64'd5);

        // Backpressure
        do_reset();
        set_rem(-1, -1, -1, -1);
        check_val("bp_rdreq_c0", 64'(q_rdreq), 64'b0001);
        tick();
        out_ready = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            check_val("bp_rdreq", 64'(q_rdreq), 64'd0);
            check_val("bp_valid", 64'(out_valid), 64'd1);
            check_val("bp_src", 64'(out_src), 64'd0);
            check_val("bp_pos", 64'(out_position), 64'd0);
            check_val("bp_data", out_data[63:0], 64'd0);
            check_val("bp_count", 64'(tok_count), 64'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check_val("bp_release_rdreq", 64'(q_rdreq), 64'b0010);
        tick();
        check_val("bp_next_valid", 64'(out_valid), 64'd1);
        check_val("bp_next_src", 64'(out_src), 64'd1);
        check_val("bp_next_count", 64'(tok_count), 64'd1);

        // Pointer wrap: grant 2, then only queues 3 and 0
        check_val("wr_rdreq2", 64'(q_rdreq), 64'b0100);
        tick();
        check_val("wr_src2", 64'(out_src), 64'd2);
        set_rem(-1, 0, 0, -1);
        check_val("wr_rdreq3", 64'(q_rdreq), 64'b1000);
        tick();
        check_val("wr_src3", 64'(out_src), 64'd3);
        check_val("wr_rdreq0", 64'(q_rdreq), 64'b0001);
        tick();
        check_val("wr_src0", 64'(out_src), 64'd0);

        // Masking: queue 2 disabled
        do_reset();
        q_enable = 4'b1011;
        set_rem(-1, -1, -1, -1);
        for (int k = 0; k < 4; k++) begin
            check_val("mask_rdreq", 64'(q_rdreq), 64'(mask_exp[k]));
            tick();
            check_val("mask_src", 64'(out_src), 64'(mask_src[k]));
        end
        check_val("mask_valid", 64'(out_valid), 64'd1);
        check_val("mask_count", 64'(tok_count), 64'd3);

        // Reset mid-stream
        rst = 1'b1;
        #1;
        check_val("mrst_valid", 64'(out_valid), 64'd0);
        check_val("mrst_count", 64'(tok_count), 64'd0);
        check_val("mrst_rdreq", 64'(q_rdreq), 64'd0);
        check_val("mrst_src", 64'(out_src), 64'd0);
        @(posedge clk);
        #1;
        q_enable = '1;
        rst = 1'b0;
        #1;
        check_val("mrst_first_rdreq", 64'(q_rdreq), 64'b0001);
        tick();
        check_val("mrst_first_src", 64'(out_src), 64'd0);
        check_val("mrst_first_valid", 64'(out_valid), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_token_queue_arbiter
`default_nettype wire
